// File: rtl/ram_bist_if.sv
// User-side access bus of ram_bist: a bit-masked write port and a registered read port.
interface ram_bist_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              usr_we;
    logic [ADDR_W-1:0] usr_waddr;
    logic [DATA_W-1:0] usr_wdata;
    logic [DATA_W-1:0] usr_mask;
    logic              usr_re;
    logic [ADDR_W-1:0] usr_raddr;
    logic [DATA_W-1:0] usr_rdata;
    logic              usr_rvalid;

    modport master (
        output usr_we, usr_waddr, usr_wdata, usr_mask, usr_re, usr_raddr,
        input  usr_rdata, usr_rvalid
    );

    modport slave (
        input  usr_we, usr_waddr, usr_wdata, usr_mask, usr_re, usr_raddr,
        output usr_rdata, usr_rvalid
    );
endinterface

// File: rtl/ram_bist.sv
// Simple dual-port RAM with a built-in self-test engine: write a pattern to every
// address, read it back, count mismatches and remember the first failing address.
module ram_bist #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              fault_en,
    input  logic [ADDR_W-1:0] fault_addr,
    ram_bist_if.slave         usr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int N = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        mode_q;
    logic              user_phase;
    logic              start_acc;
    logic              last_addr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_mask;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    logic              chk_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] exp_addr_q;

    logic [DATA_W-1:0] mem [N];

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] chk;
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) chk[i] = (i % 2 == 1);
        case (m)
            2'd0:    p = '1;
            2'd1:    p = a[0] ? ~chk : chk;
            2'd2:    p = DATA_W'(a);
            default: p = ~DATA_W'(a);
        endcase
        return p;
    endfunction

    assign user_phase = (state == IDLE) || (state == DONE);
    assign start_acc  = user_phase && start;
    assign last_addr  = &addr_cnt;
    assign busy       = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign pass       = done && (err_count == '0);
    assign usr.usr_rdata = ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_waddr = usr.usr_waddr;
        ram_wdata = usr.usr_wdata;
        ram_mask  = usr.usr_mask;
        ram_re    = 1'b0;
        ram_raddr = usr.usr_raddr;
        case (state)
            IDLE, DONE: begin
                ram_re = usr.usr_re;
                if (start) state_nx = WRITE;
                else       ram_we   = usr.usr_we;
            end
            WRITE: begin
                ram_we    = 1'b1;
                ram_waddr = addr_cnt;
                ram_wdata = pattern(mode_q, addr_cnt)
                          ^ DATA_W'(fault_en && (addr_cnt == fault_addr));
                ram_mask  = '0;
                if (last_addr) state_nx = READ;
            end
            READ: begin
                ram_re    = 1'b1;
                ram_raddr = addr_cnt;
                if (last_addr) state_nx = DRAIN;
            end
            DRAIN:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the array has no reset so it maps onto block RAM and survives rst;
    // non-blocking writes make a same-address read return the old word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W; i++) begin
            if (ram_we && !ram_mask[i]) mem[ram_waddr][i] <= ram_wdata[i];
        end
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt       <= '0;
            mode_q         <= '0;
            done           <= 1'b0;
            err_count      <= '0;
            err_addr       <= '0;
            chk_q          <= 1'b0;
            exp_q          <= '0;
            exp_addr_q     <= '0;
            usr.usr_rvalid <= 1'b0;
        end else begin
            usr.usr_rvalid <= usr.usr_re && user_phase && !start;
            // Expected word and address trail the read by one cycle to meet the data.
            chk_q      <= (state == READ);
            exp_q      <= pattern(mode_q, addr_cnt);
            exp_addr_q <= addr_cnt;
            if (start_acc) begin
                mode_q    <= mode;
                addr_cnt  <= '0;
                done      <= 1'b0;
                err_count <= '0;
                err_addr  <= '0;
            end else begin
                if (state == WRITE || state == READ) addr_cnt <= addr_cnt + 1'b1;
                if (state == DRAIN) done <= 1'b1;
                if (chk_q && (ram_rdata != exp_q)) begin
                    if (err_count == '0) err_addr <= exp_addr_q;
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: user port behaviour, clean and faulty BIST runs,
// start/reset corner cases, all against hand-computed expectations.
module tb_ram_bist;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int RUN_LEN = 513;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic              fault_en;
    logic [ADDR_W-1:0] fault_addr;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    ram_bist_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bus ();

    ram_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .fault_en   (fault_en),
        .fault_addr (fault_addr),
        .usr        (u_bus.slave),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        u_bus.usr_we    = 1'b0;
        u_bus.usr_waddr = '0;
        u_bus.usr_wdata = '0;
        u_bus.usr_mask  = '0;
        u_bus.usr_re    = 1'b0;
        u_bus.usr_raddr = '0;
    endtask

    task automatic usr_write(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        u_bus.usr_we    = 1'b1;
        u_bus.usr_waddr = a;
        u_bus.usr_wdata = d;
        u_bus.usr_mask  = m;
        tick();
        u_bus.usr_we    = 1'b0;
    endtask

    task automatic usr_read(input logic [7:0] a, output logic [15:0] d, output logic v);
        u_bus.usr_re    = 1'b1;
        u_bus.usr_raddr = a;
        tick();
        d = u_bus.usr_rdata;
        v = u_bus.usr_rvalid;
        u_bus.usr_re    = 1'b0;
    endtask

    // Pulse start, then count cycles with busy high (bounded). Optionally re-pulse
    // start mid-run, and drive user traffic at address 0x10 throughout the run.
    task automatic run_bist(input logic [1:0] m, input logic fen, input logic [7:0] fa,
                            input bit restart, input bit poke,
                            output int cycles, output bit rv_seen);
        mode       = m;
        fault_en   = fen;
        fault_addr = fa;
        start      = 1'b1;
        tick();
        start   = 1'b0;
        cycles  = 0;
        rv_seen = 1'b0;
        while (busy === 1'b1 && cycles < 2000) begin
            cycles++;
            start = restart && (cycles == 10);
            if (poke) begin
                u_bus.usr_we    = 1'b1;
                u_bus.usr_waddr = 8'h10;
                u_bus.usr_wdata = 16'h0000;
                u_bus.usr_mask  = 16'h0000;
                u_bus.usr_re    = 1'b1;
                u_bus.usr_raddr = 8'h10;
            end
            tick();
            if (u_bus.usr_rvalid !== 1'b0) rv_seen = 1'b1;
        end
        start    = 1'b0;
        fault_en = 1'b0;
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        rv;
        int          cyc;
        bit          seen;

        rst        = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        fault_en   = 1'b0;
        fault_addr = '0;
        bus_idle();
        repeat (3) tick();
        check("rst busy",       busy,             0);
        check("rst done",       done,             0);
        check("rst pass",       pass,             0);
        check("rst rvalid",     u_bus.usr_rvalid, 0);
        check("rst err_count",  err_count,        0);
        check("rst err_addr",   err_addr,         0);
        rst = 1'b0;
        tick();

        // Masked write: high byte blocked, low byte taken.
        usr_write(8'h03, 16'hFFFF, 16'h0000);
        usr_write(8'h03, 16'h1234, 16'hFF00);
        usr_read(8'h03, rd, rv);
        check("mask rvalid", rv, 1);
        check("mask rdata",  rd, 16'hFF34);
        tick();
        check("rvalid idle", u_bus.usr_rvalid, 0);

        // Read and write to one address in the same cycle returns the old word.
        usr_write(8'h04, 16'h1111, 16'h0000);
        u_bus.usr_we    = 1'b1;
        u_bus.usr_waddr = 8'h04;
        u_bus.usr_wdata = 16'h2222;
        usr_read(8'h04, rd, rv);
        u_bus.usr_we = 1'b0;
        check("rdw old data", rd, 16'h1111);
        usr_read(8'h04, rd, rv);
        check("rdw new data", rd, 16'h2222);

        // Clean checkerboard run, with a second start pulse that must be ignored.
        run_bist(2'd1, 1'b0, 8'h00, 1'b1, 1'b0, cyc, seen);
        check("m1 busy cycles", cyc,       RUN_LEN);
        check("m1 done",        done,      1);
        check("m1 pass",        pass,      1);
        check("m1 err_count",   err_count, 0);
        check("m1 err_addr",    err_addr,  0);
        usr_read(8'h21, rd, rv);
        check("m1 odd word",    rd,        16'h5555);

        // start with usr_we in DONE: run starts, write to 0x80 is dropped.
        mode = 2'd0;
        start = 1'b1;
        u_bus.usr_we    = 1'b1;
        u_bus.usr_waddr = 8'h80;
        u_bus.usr_wdata = 16'h1234;
        u_bus.usr_mask  = 16'h0000;
        tick();
        start = 1'b0;
        bus_idle();
        check("start+we busy", busy, 1);
        check("start+we done", done, 0);
        tick();
        rst = 1'b1;
        tick();
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        rst = 1'b0;
        usr_read(8'h80, rd, rv);
        check("start+we dropped", rd, 16'hAAAA);

        // Inverse-address run with user traffic during busy.
        run_bist(2'd3, 1'b0, 8'h00, 1'b0, 1'b1, cyc, seen);
        check("m3 busy cycles", cyc,  RUN_LEN);
        check("m3 pass",        pass, 1);
        check("m3 rvalid busy", seen, 0);
        usr_read(8'h10, rd, rv);
        check("m3 rvalid",      rv,   1);
        check("m3 word 0x10",   rd,   16'hFFEF);

        // Fault injection at address 5 in address mode.
        run_bist(2'd2, 1'b1, 8'h05, 1'b0, 1'b0, cyc, seen);
        check("flt5 done",      done,      1);
        check("flt5 pass",      pass,      0);
        check("flt5 err_count", err_count, 1);
        check("flt5 err_addr",  err_addr,  8'h05);
        usr_read(8'h05, rd, rv);
        check("flt5 word",      rd,        16'h0004);

        // Fault at the last address is caught in the drain cycle.
        run_bist(2'd0, 1'b1, 8'hFF, 1'b0, 1'b0, cyc, seen);
        check("fltFF err_count", err_count, 1);
        check("fltFF err_addr",  err_addr,  8'hFF);
        check("fltFF pass",      pass,      0);

        // Reset at cycle 300 of a faulty run, then restart straight after release.
        mode       = 2'd2;
        fault_en   = 1'b1;
        fault_addr = 8'h05;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (299) tick();
        check("mid busy",      busy,      1);
        check("mid err_count", err_count, 1);
        rst = 1'b1;
        tick();
        fault_en = 1'b0;
        check("rst mid busy",      busy,      0);
        check("rst mid done",      done,      0);
        check("rst mid err_count", err_count, 0);
        rst = 1'b0;
        run_bist(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, cyc, seen);
        check("post-rst cycles", cyc,  RUN_LEN);
        check("post-rst done",   done, 1);
        check("post-rst pass",   pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
